// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if -- request/response bus between the M-extension issue
// controller and the multiplier datapath.
//
// Signals:
//   m_in_valid      ctrl -> mul  operand request valid
//   m_flush         ctrl -> mul  cancel the op currently inside the multiplier
//   m_mulw          ctrl -> mul  32-bit word op (operands already sign-extended)
//   m_mul_signed    ctrl -> mul  {multiplicand signed, multiplier signed}
//   m_multiplicand  ctrl -> mul  operand A
//   m_multiplier    ctrl -> mul  operand B
//   m_out_ready     mul -> ctrl  multiplier can take a request this cycle
//   m_out_valid     mul -> ctrl  one-cycle result pulse
//   m_result_hi/lo  mul -> ctrl  128-bit product, valid with m_out_valid
//
// Modports: master = issue controller side, slave = multiplier side.
interface mul_issue_ctrl_if;
    logic        m_in_valid;
    logic        m_flush;
    logic        m_mulw;
    logic [1:0]  m_mul_signed;
    logic [63:0] m_multiplicand;
    logic [63:0] m_multiplier;
    logic        m_out_ready;
    logic        m_out_valid;
    logic [63:0] m_result_hi;
    logic [63:0] m_result_lo;

    modport master (
        output m_in_valid, m_flush, m_mulw, m_mul_signed,
               m_multiplicand, m_multiplier,
        input  m_out_ready, m_out_valid, m_result_hi, m_result_lo
    );

    modport slave (
        input  m_in_valid, m_flush, m_mulw, m_mul_signed,
               m_multiplicand, m_multiplier,
        output m_out_ready, m_out_valid, m_result_hi, m_result_lo
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl -- sequences one RISC-V M-extension multiply at a time from
// the EX stage through an external multiplier and hands the result to WB.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     EX-side handshake; in_op/in_rs1/in_rs2/in_rd latched
//                         on acceptance (in_op: 000 MUL, 001 MULH, 010 MULHSU,
//                         011 MULHU, 100 MULW, others illegal -> result 0)
//   flush                 abandon the op in flight (highest priority)
//   out_valid/out_ready   WB-side handshake with out_result/out_rd
//   mul                   multiplier bus (mul_issue_ctrl_if.master)
//
// Build option: define MUL_ZERO_BYPASS_EN to complete legal ops with a zero
// operand directly (result 0) without requesting the multiplier.
module mul_issue_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [63:0] in_rs1,
    input  logic [63:0] in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_rd,
    mul_issue_ctrl_if.master mul
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_MULW   = 3'b100;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [63:0] result_q;
    logic [63:0] mcand_q, mplier_q;
    logic [1:0]  sign_q;
    logic        mulw_q;

    logic        accept, legal, zero_bypass, in_mulw;
    logic [63:0] acc_mcand, acc_mplier, sel_result;
    logic [1:0]  acc_sign;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Decode of the op being presented, used only on acceptance.
    always_comb begin
        legal      = (in_op <= OP_MULW);
        in_mulw    = (in_op == OP_MULW);
        acc_mcand  = in_mulw ? sext32(in_rs1[31:0]) : in_rs1;
        acc_mplier = in_mulw ? sext32(in_rs2[31:0]) : in_rs2;
        case (in_op)
            OP_MULHSU: acc_sign = 2'b10;
            OP_MULHU:  acc_sign = 2'b00;
            default:   acc_sign = 2'b11;
        endcase
    end

`ifdef MUL_ZERO_BYPASS_EN
    // For MULW the extended operands are zero exactly when the low word is.
    assign zero_bypass = legal && ((acc_mcand == '0) || (acc_mplier == '0));
`else
    assign zero_bypass = 1'b0;
`endif

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        case (op_q)
            OP_MUL:  sel_result = mul.m_result_lo;
            OP_MULW: sel_result = sext32(mul.m_result_lo[31:0]);
            default: sel_result = mul.m_result_hi;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (accept) state_d = (legal && !zero_bypass) ? ISSUE : DONE;
                ISSUE: if (mul.m_out_ready) state_d = WAIT;
                WAIT:  if (mul.m_out_valid) state_d = DONE;
                DONE:  if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= '0;
            mulw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= in_op;
                rd_q <= in_rd;
                if (legal && !zero_bypass) begin
                    mcand_q  <= acc_mcand;
                    mplier_q <= acc_mplier;
                    sign_q   <= acc_sign;
                    mulw_q   <= in_mulw;
                end else begin
                    result_q <= '0;
                end
            end
            // Results arriving outside WAIT (after a flush) are dropped here.
            if (state_q == WAIT && mul.m_out_valid && !flush) begin
                result_q <= sel_result;
            end
        end
    end

    // Request is withdrawn in a flush cycle so the multiplier never sees a
    // request and a cancel together.
    assign mul.m_in_valid     = (state_q == ISSUE) && !flush;
    assign mul.m_flush        = flush && (state_q == ISSUE || state_q == WAIT);
    assign mul.m_mulw         = mulw_q;
    assign mul.m_mul_signed   = sign_q;
    assign mul.m_multiplicand = mcand_q;
    assign mul.m_multiplier   = mplier_q;

    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;
    assign out_rd     = rd_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl -- self-checking bench for mul_issue_ctrl with a
// behavioural multiplier of programmable latency and a result scoreboard.
module tb_mul_issue_ctrl;

`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_rs1, in_rs2;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;

    mul_issue_ctrl_if mb();

    mul_issue_ctrl dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .mul(mb)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [63:0] a, b;
        logic [4:0]  rd;
        logic [63:0] res;
        bit          issue;
        logic [1:0]  sg;
        bit          mulw;
        int          lat, stall, hold;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] sb_res[$];
    logic [4:0]  sb_rd[$];

    // multiplier model state
    int          mlat = 3;
    bit          ignore_flush = 1'b0;
    int          issue_cnt = 0;
    int          miv_cycles = 0;
    logic [1:0]  last_sign;
    logic        last_mulw;
    logic [63:0] last_mcand, last_mplier;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] sg);
        logic signed [129:0] ax, bx, p;
        ax = sg[1] ? {{66{a[63]}}, a} : {66'b0, a};
        bx = sg[0] ? {{66{b[63]}}, b} : {66'b0, b};
        p  = ax * bx;
        return p[127:0];
    endfunction

    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [127:0] p;
        case (op)
            3'd0: begin p = prod(a, b, 2'b11); return p[63:0]; end
            3'd1: begin p = prod(a, b, 2'b11); return p[127:64]; end
            3'd2: begin p = prod(a, b, 2'b10); return p[127:64]; end
            3'd3: begin p = prod(a, b, 2'b00); return p[127:64]; end
            3'd4: begin
                p = prod(sext32(a[31:0]), sext32(b[31:0]), 2'b11);
                return sext32(p[31:0]);
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic vec_t mk(input string name, input logic [2:0] op, input logic [63:0] a,
                                input logic [63:0] b, input logic [4:0] rd, input logic [63:0] res,
                                input bit issue, input logic [1:0] sg, input bit mulw,
                                input int lat, input int stall, input int hold);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.rd = rd; v.res = res;
        v.issue = issue; v.sg = sg; v.mulw = mulw;
        v.lat = lat; v.stall = stall; v.hold = hold;
        return v;
    endfunction

    // Behavioural multiplier: request seen at an edge, result pulse 'mlat'
    // cycles later; operands outside the pulse are random garbage.
    initial begin
        int          cnt;
        bit          hs, kill;
        logic [127:0] p, pend;
        cnt = 0;
        pend = '0;
        mb.m_out_valid = 1'b0;
        mb.m_result_hi = '0;
        mb.m_result_lo = '0;
        forever begin
            @(negedge clock);
            hs   = mb.m_in_valid && mb.m_out_ready && !reset;
            kill = reset || (mb.m_flush && !ignore_flush);
            if (mb.m_in_valid) miv_cycles++;
            if (hs) begin
                issue_cnt++;
                last_sign   = mb.m_mul_signed;
                last_mulw   = mb.m_mulw;
                last_mcand  = mb.m_multiplicand;
                last_mplier = mb.m_multiplier;
                p = prod(mb.m_multiplicand, mb.m_multiplier, mb.m_mul_signed);
            end
            @(posedge clock);
            #1;
            mb.m_out_valid = 1'b0;
            mb.m_result_hi = {$urandom, $urandom};
            mb.m_result_lo = {$urandom, $urandom};
            if (kill) cnt = 0;
            if (hs && !kill) begin
                cnt  = mlat;
                pend = p;
            end
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    mb.m_out_valid = 1'b1;
                    mb.m_result_hi = pend[127:64];
                    mb.m_result_lo = pend[63:0];
                end
            end
        end
    end

    task automatic run_op(input vec_t v);
        int          cyc, ic0, mv0;
        bit          got;
        logic [63:0] exp_a, exp_b, exp_r;
        logic [4:0]  exp_rd;
        tick();
        ic0  = issue_cnt;
        mv0  = miv_cycles;
        mlat = v.lat;
        if (v.stall > 0) mb.m_out_ready = 1'b0;
        in_valid = 1'b1; in_op = v.op; in_rs1 = v.a; in_rs2 = v.b; in_rd = v.rd;
        @(negedge clock);
        chk({v.name, ":in_ready"}, in_ready, 1);
        sb_res.push_back(v.res);
        sb_rd.push_back(v.rd);
        tick();
        in_valid = 1'b0;
        in_op = 3'($urandom); in_rs1 = {$urandom, $urandom}; in_rs2 = {$urandom, $urandom};
        in_rd = ~v.rd;
        cyc = 1;
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clock);
            chk({v.name, ":stall_m_in_valid"}, mb.m_in_valid, 1);
            tick();
            cyc++;
        end
        mb.m_out_ready = 1'b1;
        got = 1'b0;
        repeat (300) begin
            @(negedge clock);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        chk({v.name, ":out_valid_seen"}, got, 1);
        if (!got) return;
        chk({v.name, ":latency"}, cyc, v.issue ? (v.lat + 2 + v.stall) : 1);
        chk({v.name, ":in_ready_done"}, in_ready, 0);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            @(negedge clock);
            chk({v.name, ":hold_valid"}, out_valid, 1);
            chk({v.name, ":hold_result"}, out_result, v.res);
            chk({v.name, ":hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        if (sb_res.size() == 0) begin
            chk({v.name, ":scoreboard_empty"}, 1, 0);
        end else begin
            exp_r  = sb_res.pop_front();
            exp_rd = sb_rd.pop_front();
            chk({v.name, ":out_result"}, out_result, exp_r);
            chk({v.name, ":out_rd"}, out_rd, exp_rd);
        end
        tick();
        out_ready = 1'b0;
        @(negedge clock);
        chk({v.name, ":out_valid_drop"}, out_valid, 0);
        chk({v.name, ":in_ready_back"}, in_ready, 1);
        if (v.issue) begin
            exp_a = (v.op == 3'd4) ? sext32(v.a[31:0]) : v.a;
            exp_b = (v.op == 3'd4) ? sext32(v.b[31:0]) : v.b;
            chk({v.name, ":issue_count"}, issue_cnt - ic0, 1);
            chk({v.name, ":m_mul_signed"}, last_sign, v.sg);
            chk({v.name, ":m_mulw"}, last_mulw, v.mulw);
            chk({v.name, ":m_multiplicand"}, last_mcand, exp_a);
            chk({v.name, ":m_multiplier"}, last_mplier, exp_b);
        end else begin
            chk({v.name, ":no_m_in_valid"}, miv_cycles - mv0, 0);
        end
    endtask

    task automatic wait_out_valid(input string name);
        bit got;
        got = 1'b0;
        repeat (300) begin
            @(negedge clock);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk({name, ":out_valid_seen"}, got, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[$];
        vec_t v;
        int   ov_seen;

        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        flush = 1'b0; out_ready = 1'b0; mb.m_out_ready = 1'b1;

        vt.push_back(mk("mul_neg", 3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd1,
                        64'hFFFF_FFFF_FFFF_FFFA, 1, 2'b11, 0, 3, 0, 5));
        vt.push_back(mk("mulhu_max", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2,
                        64'd1, 1, 2'b00, 0, 2, 0, 0));
        vt.push_back(mk("mulhsu_max", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3,
                        64'hFFFF_FFFF_FFFF_FFFF, 1, 2'b10, 0, 1, 2, 0));
        vt.push_back(mk("mulh_neg", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4,
                        64'hFFFF_FFFF_FFFF_FFFF, 1, 2'b11, 0, 4, 0, 1));
        vt.push_back(mk("mulw_ovf", 3'd4, 64'h1234_5678_4000_0000, 64'd2, 5'd5,
                        64'hFFFF_FFFF_8000_0000, 1, 2'b11, 1, 2, 0, 0));
        vt.push_back(mk("mulw_neg", 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_7FFF_FFFF, 5'd6,
                        64'hFFFF_FFFF_8000_0001, 1, 2'b11, 1, 1, 0, 0));
        vt.push_back(mk("mulhu_top", 3'd3, 64'h8000_0000_0000_0000, 64'd4, 5'd7,
                        64'd2, 1, 2'b00, 0, 3, 0, 0));
        vt.push_back(mk("illegal_101", 3'd5, 64'd123, 64'd456, 5'd8,
                        64'd0, 0, 2'b00, 0, 1, 0, 0));
        vt.push_back(mk("illegal_111", 3'd7, 64'd77, 64'd99, 5'd9,
                        64'd0, 0, 2'b00, 0, 1, 0, 2));
        vt.push_back(mk("mul_zero", 3'd0, 64'd0, 64'd9, 5'd10,
                        64'd0, !BYP, 2'b11, 0, 4, 0, 0));
        vt.push_back(mk("mulw_zero_lo", 3'd4, 64'h1234_5678_0000_0000, 64'd5, 5'd11,
                        64'd0, !BYP, 2'b11, 1, 2, 0, 0));

        // reset state
        tick(); tick();
        @(negedge clock);
        chk("rst:in_ready", in_ready, 1);
        chk("rst:out_valid", out_valid, 0);
        chk("rst:out_result", out_result, 0);
        chk("rst:out_rd", out_rd, 0);
        chk("rst:m_in_valid", mb.m_in_valid, 0);
        chk("rst:m_flush", mb.m_flush, 0);
        chk("rst:m_mulw", mb.m_mulw, 0);
        chk("rst:m_mul_signed", mb.m_mul_signed, 0);
        chk("rst:m_multiplicand", mb.m_multiplicand, 0);
        chk("rst:m_multiplier", mb.m_multiplier, 0);
        tick();
        reset = 1'b0;

        foreach (vt[i]) run_op(vt[i]);

        // random legal ops checked against the ISA reference
        for (int i = 0; i < 6; i++) begin
            v.op = 3'($urandom_range(0, 4));
            v.a = {$urandom, $urandom}; v.b = {$urandom, $urandom};
            v.rd = 5'($urandom);
            v.res = ref_res(v.op, v.a, v.b);
            v.issue = 1'b1;
            v.sg = (v.op == 3'd2) ? 2'b10 : (v.op == 3'd3) ? 2'b00 : 2'b11;
            v.mulw = (v.op == 3'd4);
            v.lat = $urandom_range(1, 4); v.stall = 0; v.hold = $urandom_range(0, 1);
            v.name = $sformatf("rand%0d", i);
            run_op(v);
        end

        // flush deep in WAIT; the multiplier keeps running so its result shows up stale
        ignore_flush = 1'b1;
        mlat = 20;
        tick();
        in_valid = 1'b1; in_op = 3'd0; in_rs1 = 64'd11; in_rs2 = 64'd13; in_rd = 5'd3;
        @(negedge clock);
        chk("fw:in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        tick();
        repeat (10) tick();
        flush = 1'b1;
        @(negedge clock);
        chk("fw:m_flush_pulse", mb.m_flush, 1);
        tick();
        flush = 1'b0;
        @(negedge clock);
        chk("fw:m_flush_end", mb.m_flush, 0);
        chk("fw:idle", in_ready, 1);
        ov_seen = 0;
        repeat (15) begin
            tick();
            @(negedge clock);
            if (out_valid) ov_seen++;
        end
        chk("fw:stale_ignored", ov_seen, 0);
        ignore_flush = 1'b0;
        run_op(mk("mul_5x7", 3'd0, 64'd5, 64'd7, 5'd12, 64'd35, 1, 2'b11, 0, 3, 0, 0));

        // flush alongside in_valid blocks acceptance
        tick();
        flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_rs1 = 64'd2; in_rs2 = 64'd2;
        @(negedge clock);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("fv:not_accepted", in_ready, 1);
        chk("fv:no_request", mb.m_in_valid, 0);

        // flush in ISSUE while the multiplier stalls
        tick();
        mb.m_out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd1; in_rs1 = 64'd5; in_rs2 = 64'd6;
        @(negedge clock);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clock);
        chk("fi:m_flush_pulse", mb.m_flush, 1);
        tick();
        flush = 1'b0; mb.m_out_ready = 1'b1;
        @(negedge clock);
        chk("fi:idle", in_ready, 1);
        chk("fi:m_flush_end", mb.m_flush, 0);

        // flush in DONE: no multiplier cancel, out_valid drops next cycle
        tick();
        mlat = 2;
        in_valid = 1'b1; in_op = 3'd0; in_rs1 = 64'd4; in_rs2 = 64'd4;
        @(negedge clock);
        tick();
        in_valid = 1'b0;
        wait_out_valid("fd");
        tick();
        flush = 1'b1;
        @(negedge clock);
        chk("fd:valid_before", out_valid, 1);
        chk("fd:no_m_flush", mb.m_flush, 0);
        tick();
        flush = 1'b0;
        @(negedge clock);
        chk("fd:valid_drop", out_valid, 0);
        chk("fd:idle", in_ready, 1);

        // reset mid-operation
        tick();
        mlat = 6;
        in_valid = 1'b1; in_op = 3'd0; in_rs1 = 64'd9; in_rs2 = 64'd9; in_rd = 5'd17;
        @(negedge clock);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rm:in_ready", in_ready, 1);
        chk("rm:out_rd", out_rd, 0);
        chk("rm:m_in_valid", mb.m_in_valid, 0);
        chk("rm:m_multiplicand", mb.m_multiplicand, 0);
        chk("rm:m_mul_signed", mb.m_mul_signed, 0);
        ov_seen = 0;
        repeat (10) begin
            tick();
            @(negedge clock);
            if (out_valid) ov_seen++;
        end
        chk("rm:no_output", ov_seen, 0);

        run_op(mk("post_reset_mul", 3'd0, 64'd6, 64'd7, 5'd20, 64'd42, 1, 2'b11, 0, 1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
